// File: rtl/axi_stream_downsizer.sv
// Splits one wide AXI-Stream beat into RATIO narrow beats, least-significant slice first.
// Optional feature: define AXIS_DOWNSIZER_SKIP_EMPTY_EN to suppress slices whose keep bits are all zero.
module axi_stream_downsizer #(
  parameter int OUT_WIDTH = 32,
  parameter int RATIO     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic [OUT_WIDTH*RATIO-1:0]      data_in,
  input  logic [(OUT_WIDTH/8)*RATIO-1:0]  keep_in,
  input  logic                            last_in,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic [OUT_WIDTH-1:0]            data_out,
  output logic [OUT_WIDTH/8-1:0]          keep_out,
  output logic                            last_out
);

  localparam int IN_WIDTH = OUT_WIDTH * RATIO;
  localparam int KO       = OUT_WIDTH / 8;
  localparam int KI       = KO * RATIO;
  localparam int IW       = (RATIO > 2) ? $clog2(RATIO) : 1;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] data_q;
  logic [KI-1:0]       keep_q;
  logic                last_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       fin;

  logic [IW-1:0]       start_idx;
  logic [IW-1:0]       start_fin;
  logic [IW-1:0]       next_idx;
  logic                load;
  logic                at_fin;
  logic                accept;
  logic                complete;

  assign at_fin    = (idx == fin);
  // Ready depends combinationally on ready_in so a new wide beat can land on the final slice.
  assign ready_out = (state == EMPTY) || ((state == SEND) && at_fin && ready_in);
  assign accept    = valid_in && ready_out;
  assign complete  = (state == SEND) && ready_in && at_fin;

`ifdef AXIS_DOWNSIZER_SKIP_EMPTY_EN
  logic [RATIO-1:0] in_nz;
  logic [RATIO-1:0] hold_nz;

  always_comb begin
    in_nz     = '0;
    hold_nz   = '0;
    start_idx = '0;
    start_fin = '0;
    next_idx  = idx + IW'(1);
    for (int r = 0; r < RATIO; r++) begin
      in_nz[r]   = |keep_in[r*KO +: KO];
      hold_nz[r] = |keep_q[r*KO +: KO];
    end
    // Descending scan leaves the lowest qualifying slice in place.
    for (int r = RATIO - 1; r >= 0; r--) begin
      if (in_nz[r]) start_idx = IW'(r);
      if (hold_nz[r] && (IW'(r) > idx)) next_idx = IW'(r);
    end
    for (int r = 0; r < RATIO; r++) begin
      if (in_nz[r]) start_fin = IW'(r);
    end
  end

  // An all-empty, non-final beat is consumed without producing output.
  assign load = (|keep_in) || last_in;
`else
  assign start_idx = '0;
  assign start_fin = IW'(RATIO - 1);
  assign next_idx  = idx + IW'(1);
  assign load      = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      idx    <= '0;
      fin    <= IW'(RATIO - 1);
    end else begin
      if (accept && load) begin
        state  <= SEND;
        data_q <= data_in;
        keep_q <= keep_in;
        last_q <= last_in;
        idx    <= start_idx;
        fin    <= start_fin;
      end else if (complete) begin
        state <= EMPTY;
      end else if ((state == SEND) && ready_in) begin
        idx <= next_idx;
      end
    end
  end

  assign valid_out = (state == SEND);
  assign data_out  = data_q[OUT_WIDTH*idx +: OUT_WIDTH];
  assign keep_out  = keep_q[KO*idx +: KO];
  assign last_out  = last_q && at_fin;

endmodule
